src_select_ctrl: RTL and testbench
==================================

Name: src_select_ctrl

Overview:
- Input-source controller ahead of I2S_to_16LJ32fs.
- Selects between the external I2S port (ext_*) and the AES3 receiver outputs (rx_*).
- Monitors LRCK activity on each source and sequences click-free switchover: mute, drain, swap, settle, unmute.
- All control logic runs on mck. The selected bck/lrck pass through a combinational mux steered by a registered select.

Parameters:
WIN_CYCLES, 4096, activity-window length in mck cycles
MIN_EDGES, 4, minimum LRCK rising edges per window for a source to count as present
MUTE_FRAMES, 8, muted LRCK frames on the old source before the mux swaps
SETTLE_FRAMES, 16, muted LRCK frames on the new source before unmute

Ports:
mck  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ext_bck, ext_lrck, ext_data  in  1 each  external I2S source
rx_bck, rx_lrck, rx_data  in  1 each  AES3 receiver I2S outputs
rx_active  in  1  AES3 receiver lock flag
sel_req  in  1  requested source: 0 = ext, 1 = aes3 (asynchronous, user switch)
bck, lrck  out  1 each  selected clocks to the converter, combinational mux on cur_sel
data  out  1  selected data, forced to 0 while mute = 1
cur_sel  out  1  registered active source
mute  out  1  DAC/relay mute, 1 = muted
ext_present, rx_present  out  1 each  activity flags
state  out  3  FSM state, for debug

Behaviour:
- Synchronisation:
  - ext_lrck, rx_lrck, rx_active and sel_req each pass through a 2-FF synchroniser on mck.
  - LRCK rising edge = synced level 1 with previous synced level 0. This gives a one-mck-cycle pulse.
- Activity detection, per source:
  - A free-running window counter runs from 0 to WIN_CYCLES-1 and wraps.
  - An edge counter saturates at MIN_EDGES.
  - At the wrap cycle, present <= (edges >= MIN_EDGES) and the edge counter clears. An edge that lands on the wrap cycle counts toward the new window.
  - rx_present additionally requires the synced rx_active = 1 at the wrap.
  - Loss-detection latency is at most 2*WIN_CYCLES.
- Edge counting for the FSM: frm_cnt counts rising edges of the LRCK of cur_sel only.
- FSM states (encoding in package): NOSIG=0, SETTLE=1, RUN=2, DRAIN=3, SWAP=4.
  - NOSIG: mute=1.
    - sel_sync != cur_sel -> SWAP.
    - Else if the present flag of the selected source = 1 -> SETTLE, frm_cnt cleared.
  - SETTLE: mute=1.
    - sel change -> SWAP (highest priority).
    - Else selected source lost -> NOSIG.
    - Else frm_cnt reaches SETTLE_FRAMES -> RUN.
  - RUN: mute=0.
    - sel change or selected source lost -> DRAIN, frm_cnt cleared.
    - mute rises on the first cycle of DRAIN (registered output).
  - DRAIN: mute=1.
    - frm_cnt reaches MUTE_FRAMES -> SWAP.
    - Selected source lost -> SWAP immediately, with no edges to wait for.
    - If sel_sync returns to cur_sel during DRAIN, DRAIN still completes. SWAP then leaves cur_sel unchanged.
  - SWAP: exactly 1 cycle. cur_sel <= sel_sync, then -> NOSIG.
- Simultaneous events: a select change takes priority over loss in every state.
- Reset values: state=NOSIG, cur_sel=0, mute=1, frm_cnt=0, both present flags=0, all window/edge counters=0, all synchroniser stages=0. data=0 because mute=1.
- Reset mid-operation: outputs return to reset values asynchronously. No partial drain is resumed.
- Widths:
  - window counter = clog2(WIN_CYCLES).
  - frame counter = clog2(max(MUTE_FRAMES, SETTLE_FRAMES)+1).
  - Counters never wrap inside an FSM state.

Decomposition:
- Package src_select_pkg:
  - FSM state typedef/encoding.
  - SEL_EXT=0, SEL_AES3=1.
  - Default parameter constants.
- One sub-module: src_activity_det (synchroniser + edge detect + window/edge counters + present flag). Instantiated twice, once per source; its edge-pulse output is reused by the FSM.

Test Plan:
1. Reset, ext LRCK at 44.1 kHz (mck 22.5792 MHz), sel_req=0 -> ext_present=1 after first window wrap, SETTLE, RUN after 16 LRCK edges, mute 1->0, data follows ext_data.
2. RUN on ext, both sources active, sel_req 0->1 -> DRAIN 8 frames with data=0, one SWAP cycle, cur_sel=1, bck/lrck switch to rx_*, unmute 16 frames later.
3. RUN on aes3, rx_active drops -> rx_present=0 within 2*WIN_CYCLES, DRAIN -> SWAP immediately (cur_sel stays 1) -> NOSIG, mute=1; rx_active restored -> SETTLE -> RUN.
4. Source idle from reset (no LRCK edges) -> stays NOSIG, mute=1, data=0 indefinitely; sel_req toggle -> SWAP, cur_sel follows.
5. sel_req pulse 1 then back to 0 during DRAIN -> DRAIN completes 8 frames, SWAP keeps cur_sel=0, SETTLE 16 frames, RUN.
6. rst_n asserted during SETTLE -> immediately state=NOSIG, mute=1, cur_sel=0, counters 0; release resumes normal acquisition.

Source files
------------

// File: rtl/src_select_pkg.sv
`default_nettype none
// ============================================================================
// src_select_pkg : shared FSM encoding, source codes and default constants
// Rev 1.0
// ============================================================================
package src_select_pkg;

    typedef enum logic [2:0] {
        ST_NOSIG  = 3'd0,
        ST_SETTLE = 3'd1,
        ST_RUN    = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_SWAP   = 3'd4
    } state_e;

    localparam logic SEL_EXT  = 1'b0;
    localparam logic SEL_AES3 = 1'b1;

    localparam int DEF_WIN_CYCLES    = 4096;
    localparam int DEF_MIN_EDGES     = 4;
    localparam int DEF_MUTE_FRAMES   = 8;
    localparam int DEF_SETTLE_FRAMES = 16;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/src_activity_det.sv
`default_nettype none
// ============================================================================
// src_activity_det : LRCK synchroniser, rising-edge pulse and windowed presence
// Rev 1.0
// ============================================================================
module src_activity_det
    import src_select_pkg::*;
#(
    parameter int WIN_CYCLES = DEF_WIN_CYCLES,
    parameter int MIN_EDGES  = DEF_MIN_EDGES
) (
    input  logic mck,
    input  logic rst_n,
    input  logic lrck_i,
    input  logic active_i,
    output logic edge_o,
    output logic present_o
);

    localparam int WIN_W  = $clog2(WIN_CYCLES);
    localparam int EDGE_W = $clog2(MIN_EDGES + 1);

    // [0] first stage, [1] synced level, [2] previous synced level
    logic [2:0]        lrck_sync_q;
    logic [1:0]        act_sync_q;
    logic [WIN_W-1:0]  win_q;
    logic [EDGE_W-1:0] edges_q;
    logic              present_q;
    logic              w_wrap;

    assign edge_o    = lrck_sync_q[1] & ~lrck_sync_q[2];
    assign w_wrap    = (win_q == WIN_W'(WIN_CYCLES - 1));
    assign present_o = present_q;

    always_ff @(posedge mck or negedge rst_n) begin
        if (!rst_n) begin
            lrck_sync_q <= '0;
            act_sync_q  <= '0;
            win_q       <= '0;
            edges_q     <= '0;
            present_q   <= 1'b0;
        end else begin
            lrck_sync_q <= {lrck_sync_q[1:0], lrck_i};
            act_sync_q  <= {act_sync_q[0], active_i};
            if (w_wrap) begin
                win_q     <= '0;
                present_q <= (edges_q >= EDGE_W'(MIN_EDGES)) && act_sync_q[1];
                // an edge on the wrap cycle belongs to the new window
                edges_q   <= edge_o ? EDGE_W'(1) : '0;
            end else begin
                win_q <= win_q + WIN_W'(1);
                if (edge_o && (edges_q < EDGE_W'(MIN_EDGES)))
                    edges_q <= edges_q + EDGE_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/src_select_ctrl.sv
`default_nettype none
// ============================================================================
// src_select_ctrl : click-free ext / AES3 I2S source switchover controller
// Rev 1.0
// ============================================================================
module src_select_ctrl
    import src_select_pkg::*;
#(
    parameter int WIN_CYCLES    = DEF_WIN_CYCLES,
    parameter int MIN_EDGES     = DEF_MIN_EDGES,
    parameter int MUTE_FRAMES   = DEF_MUTE_FRAMES,
    parameter int SETTLE_FRAMES = DEF_SETTLE_FRAMES
) (
    input  logic       mck,
    input  logic       rst_n,
    input  logic       ext_bck,
    input  logic       ext_lrck,
    input  logic       ext_data,
    input  logic       rx_bck,
    input  logic       rx_lrck,
    input  logic       rx_data,
    input  logic       rx_active,
    input  logic       sel_req,
    output logic       bck,
    output logic       lrck,
    output logic       data,
    output logic       cur_sel,
    output logic       mute,
    output logic       ext_present,
    output logic       rx_present,
    output logic [2:0] state
);

    localparam int FRM_MAX = max2(MUTE_FRAMES, SETTLE_FRAMES);
    localparam int FRM_W   = $clog2(FRM_MAX + 1);

    logic             ext_edge;
    logic             rx_edge;
    logic [1:0]       sel_sync_q;
    state_e           state_q;
    logic             cur_sel_q;
    logic             mute_q;
    logic [FRM_W-1:0] frm_cnt_q;

    logic w_sel_sync;
    logic w_sel_chg;
    logic w_pres;
    logic w_edge;

    src_activity_det #(.WIN_CYCLES(WIN_CYCLES), .MIN_EDGES(MIN_EDGES)) u_ext_det (
        .mck       (mck),
        .rst_n     (rst_n),
        .lrck_i    (ext_lrck),
        .active_i  (1'b1),
        .edge_o    (ext_edge),
        .present_o (ext_present)
    );

    src_activity_det #(.WIN_CYCLES(WIN_CYCLES), .MIN_EDGES(MIN_EDGES)) u_rx_det (
        .mck       (mck),
        .rst_n     (rst_n),
        .lrck_i    (rx_lrck),
        .active_i  (rx_active),
        .edge_o    (rx_edge),
        .present_o (rx_present)
    );

    assign w_sel_sync = sel_sync_q[1];
    assign w_sel_chg  = (w_sel_sync != cur_sel_q);
    assign w_pres     = (cur_sel_q == SEL_AES3) ? rx_present : ext_present;
    assign w_edge     = (cur_sel_q == SEL_AES3) ? rx_edge    : ext_edge;

    always_ff @(posedge mck or negedge rst_n) begin
        if (!rst_n) begin
            sel_sync_q <= '0;
            state_q    <= ST_NOSIG;
            cur_sel_q  <= SEL_EXT;
            mute_q     <= 1'b1;
            frm_cnt_q  <= '0;
        end else begin
            sel_sync_q <= {sel_sync_q[0], sel_req};
            mute_q     <= 1'b1;
            case (state_q)
                ST_NOSIG: begin
                    frm_cnt_q <= '0;
                    if (w_sel_chg)
                        state_q <= ST_SWAP;
                    else if (w_pres)
                        state_q <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (w_sel_chg)
                        state_q <= ST_SWAP;
                    else if (!w_pres)
                        state_q <= ST_NOSIG;
                    else if (frm_cnt_q == FRM_W'(SETTLE_FRAMES)) begin
                        state_q <= ST_RUN;
                        mute_q  <= 1'b0;
                    end else if (w_edge)
                        frm_cnt_q <= frm_cnt_q + FRM_W'(1);
                end
                ST_RUN: begin
                    if (w_sel_chg || !w_pres) begin
                        state_q   <= ST_DRAIN;
                        frm_cnt_q <= '0;
                    end else
                        mute_q <= 1'b0;
                end
                ST_DRAIN: begin
                    // a lost source has no frames left to drain
                    if ((frm_cnt_q == FRM_W'(MUTE_FRAMES)) || !w_pres)
                        state_q <= ST_SWAP;
                    else if (w_edge)
                        frm_cnt_q <= frm_cnt_q + FRM_W'(1);
                end
                ST_SWAP: begin
                    cur_sel_q <= w_sel_sync;
                    frm_cnt_q <= '0;
                    state_q   <= ST_NOSIG;
                end
                default: begin
                    frm_cnt_q <= '0;
                    state_q   <= ST_NOSIG;
                end
            endcase
        end
    end

    assign bck     = (cur_sel_q == SEL_AES3) ? rx_bck  : ext_bck;
    assign lrck    = (cur_sel_q == SEL_AES3) ? rx_lrck : ext_lrck;
    assign data    = mute_q ? 1'b0 : ((cur_sel_q == SEL_AES3) ? rx_data : ext_data);
    assign cur_sel = cur_sel_q;
    assign mute    = mute_q;
    assign state   = state_q;

endmodule
`default_nettype wire

// File: tb/tb_src_select_ctrl.sv
`default_nettype none
// ============================================================================
// tb_src_select_ctrl : directed bench with a behavioural reference model
// Rev 1.0
// ============================================================================
module tb_src_select_ctrl;

    localparam int W  = 64;
    localparam int ME = 4;
    localparam int MF = 8;
    localparam int SF = 16;

    logic       mck = 1'b0;
    logic       rst_n = 1'b0;
    logic       ext_bck = 1'b0, ext_lrck = 1'b0, ext_data = 1'b0;
    logic       rx_bck = 1'b0, rx_lrck = 1'b0, rx_data = 1'b0;
    logic       rx_active = 1'b1;
    logic       sel_req = 1'b0;
    logic       bck, lrck, data, cur_sel, mute, ext_present, rx_present;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;
    bit ext_en = 1'b1;
    bit rx_en  = 1'b1;
    int ph_e = 0;
    int ph_r = 0;

    src_select_ctrl #(
        .WIN_CYCLES(W), .MIN_EDGES(ME), .MUTE_FRAMES(MF), .SETTLE_FRAMES(SF)
    ) dut (
        .mck(mck), .rst_n(rst_n),
        .ext_bck(ext_bck), .ext_lrck(ext_lrck), .ext_data(ext_data),
        .rx_bck(rx_bck), .rx_lrck(rx_lrck), .rx_data(rx_data),
        .rx_active(rx_active), .sel_req(sel_req),
        .bck(bck), .lrck(lrck), .data(data), .cur_sel(cur_sel), .mute(mute),
        .ext_present(ext_present), .rx_present(rx_present), .state(state)
    );

    always #5 mck = ~mck;

    // Sources: ext LRCK period 8 mck, rx LRCK period 10 mck
    always @(posedge mck) begin
        #2;
        ph_e = ph_e + 1;
        ph_r = (ph_r + 1) % 10;
        ext_lrck = ext_en && (((ph_e / 4) % 2) == 1);
        rx_lrck  = rx_en && (ph_r < 5);
        ext_bck  = ~ext_bck;
        rx_bck   = ~rx_bck;
        ext_data = ($urandom_range(0, 1) != 0);
        rx_data  = ($urandom_range(0, 1) != 0);
    end

    // ---------------- behavioural model ----------------
    // History bit k holds the input sampled k+1 edges ago.
    int       m_st, m_frames, m_win, m_ecnt, m_rcnt;
    bit       m_cur, m_mute, m_extp, m_rxp;
    bit [2:0] h_e, h_r, h_s, h_a;
    bit       m_ee, m_re, m_sel, m_act, m_pres, m_ed;

    always @(posedge mck or negedge rst_n) begin
        if (!rst_n) begin
            m_st = 0; m_frames = 0; m_win = 0; m_ecnt = 0; m_rcnt = 0;
            m_cur = 0; m_mute = 1; m_extp = 0; m_rxp = 0;
            h_e = 0; h_r = 0; h_s = 0; h_a = 0;
        end else begin
            m_ee   = h_e[1] && !h_e[2];
            m_re   = h_r[1] && !h_r[2];
            m_sel  = h_s[1];
            m_act  = h_a[1];
            m_pres = m_cur ? m_rxp : m_extp;
            m_ed   = m_cur ? m_re : m_ee;
            case (m_st)
                0: if (m_sel != m_cur) m_st = 4;
                   else if (m_pres) begin m_st = 1; m_frames = 0; end
                1: if (m_sel != m_cur) m_st = 4;
                   else if (!m_pres) m_st = 0;
                   else if (m_frames >= SF) m_st = 2;
                   else m_frames = m_frames + int'(m_ed);
                2: if (m_sel != m_cur || !m_pres) begin m_st = 3; m_frames = 0; end
                3: if (m_frames >= MF || !m_pres) m_st = 4;
                   else m_frames = m_frames + int'(m_ed);
                default: begin m_cur = m_sel; m_st = 0; end
            endcase
            m_mute = (m_st != 2);
            if (m_win == W - 1) begin
                m_extp = (m_ecnt >= ME);
                m_rxp  = (m_rcnt >= ME) && m_act;
                m_ecnt = int'(m_ee);
                m_rcnt = int'(m_re);
                m_win  = 0;
            end else begin
                m_ecnt = m_ecnt + int'(m_ee);
                m_rcnt = m_rcnt + int'(m_re);
                m_win  = m_win + 1;
            end
            h_e = {h_e[1:0], ext_lrck};
            h_r = {h_r[1:0], rx_lrck};
            h_s = {h_s[1:0], sel_req};
            h_a = {h_a[1:0], rx_active};
        end
    end

    // Every-cycle comparison against the model
    always @(negedge mck) begin
        logic e_bck, e_lrck, e_data;
        e_bck  = m_cur ? rx_bck  : ext_bck;
        e_lrck = m_cur ? rx_lrck : ext_lrck;
        e_data = m_mute ? 1'b0 : (m_cur ? rx_data : ext_data);
        checks = checks + 1;
        if (state !== 3'(m_st) || cur_sel !== m_cur || mute !== m_mute ||
            ext_present !== m_extp || rx_present !== m_rxp ||
            bck !== e_bck || lrck !== e_lrck || data !== e_data) begin
            errors = errors + 1;
            $display("FAIL model_cmp t=%0t got st=%0d sel=%0b mute=%0b ep=%0b rp=%0b bck=%0b lrck=%0b data=%0b exp st=%0d sel=%0b mute=%0b ep=%0b rp=%0b bck=%0b lrck=%0b data=%0b",
                     $time, state, cur_sel, mute, ext_present, rx_present, bck, lrck, data,
                     m_st, m_cur, m_mute, m_extp, m_rxp, e_bck, e_lrck, e_data);
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge mck);
        #2;
    endtask

    task automatic wait_state(input logic [2:0] v, input int maxc, input string nm, output int n);
        n = 0;
        while (state !== v && n < maxc) begin
            @(negedge mck);
            n = n + 1;
        end
        checks = checks + 1;
        if (state !== v) begin
            errors = errors + 1;
            $display("FAIL %s timeout: state=%0d expected %0d", nm, state, v);
        end
    endtask

    int n;

    initial begin
        // reset state
        repeat (4) @(negedge mck);
        chk("rst_state", int'(state), 0);
        chk("rst_mute", int'(mute), 1);
        chk("rst_cur_sel", int'(cur_sel), 0);
        chk("rst_data", int'(data), 0);
        chk("rst_ext_present", int'(ext_present), 0);
        step();
        rst_n = 1'b1;

        // 1: acquire ext
        wait_state(3'd1, 300, "t1_settle", n);
        chk("t1_ext_present", int'(ext_present), 1);
        wait_state(3'd2, 400, "t1_run", n);
        @(negedge mck);
        chk("t1_mute", int'(mute), 0);
        chk("t1_data", int'(data), int'(ext_data));

        // 2: switch ext -> aes3
        step();
        sel_req = 1'b1;
        wait_state(3'd3, 20, "t2_drain", n);
        wait_state(3'd4, 100, "t2_swap", n);
        chk("t2_drain_len_ok", int'(n >= 58 && n <= 65), 1);
        @(negedge mck);
        chk("t2_cur_sel", int'(cur_sel), 1);
        chk("t2_nosig", int'(state), 0);
        wait_state(3'd2, 600, "t2_run", n);
        @(negedge mck);
        chk("t2_lrck_rx", int'(lrck), int'(rx_lrck));
        chk("t2_bck_rx", int'(bck), int'(rx_bck));

        // 3: aes3 lock lost then restored
        step();
        rx_active = 1'b0;
        wait_state(3'd3, 2 * W + 10, "t3_drain", n);
        chk("t3_rx_present", int'(rx_present), 0);
        wait_state(3'd0, 4, "t3_nosig", n);
        chk("t3_cur_sel", int'(cur_sel), 1);
        chk("t3_mute", int'(mute), 1);
        step();
        rx_active = 1'b1;
        wait_state(3'd2, 600, "t3_run", n);
        chk("t3_cur_sel_run", int'(cur_sel), 1);

        // 4: idle sources from reset
        step();
        sel_req = 1'b0; rst_n = 1'b0; ext_en = 1'b0; rx_en = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (300) @(negedge mck);
        chk("t4_state", int'(state), 0);
        chk("t4_mute", int'(mute), 1);
        chk("t4_data", int'(data), 0);
        step();
        sel_req = 1'b1;
        wait_state(3'd4, 10, "t4_swap", n);
        @(negedge mck);
        chk("t4_cur_sel", int'(cur_sel), 1);
        chk("t4_state_after", int'(state), 0);

        // 5: sel_req pulse during DRAIN
        step();
        sel_req = 1'b0; rst_n = 1'b0; ext_en = 1'b1; rx_en = 1'b1;
        repeat (3) step();
        rst_n = 1'b1;
        wait_state(3'd2, 600, "t5_run", n);
        step();
        sel_req = 1'b1;
        wait_state(3'd3, 20, "t5_drain", n);
        repeat (5) step();
        sel_req = 1'b0;
        wait_state(3'd4, 100, "t5_swap", n);
        chk("t5_drain_len_ok", int'(n >= 52 && n <= 65), 1);
        @(negedge mck);
        chk("t5_cur_sel", int'(cur_sel), 0);
        wait_state(3'd2, 400, "t5_run2", n);
        chk("t5_cur_sel_run", int'(cur_sel), 0);

        // 6: asynchronous reset during SETTLE
        step();
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        wait_state(3'd1, 300, "t6_settle", n);
        step();
        rst_n = 1'b0;
        #1;
        chk("t6_state", int'(state), 0);
        chk("t6_mute", int'(mute), 1);
        chk("t6_cur_sel", int'(cur_sel), 0);
        chk("t6_ext_present", int'(ext_present), 0);
        repeat (3) step();
        rst_n = 1'b1;
        wait_state(3'd2, 600, "t6_run", n);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
